// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and access-check helpers for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_RMW_WAIT,
    ST_RMW_CAP,
    ST_WR,
    ST_ERR
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction

  // Right-justified lane mask; shifted into place by the byte offset.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    return size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);
  logic [31:0] w_shr;
  logic [31:0] w_shl;
  logic [31:0] w_mask;

  always_comb begin
    w_shr = i_rdata >> {i_off, 3'b000};
    w_shl = i_wdata << {i_off, 3'b000};
    w_mask = lane_mask(i_size) << {i_off, 3'b000};
    o_load_data = i_size == SZ_BYTE ? {{24{i_signed & w_shr[7]}}, w_shr[7:0]} :
                  i_size == SZ_HALF ? {{16{i_signed & w_shr[15]}}, w_shr[15:0]} : i_rdata;
    o_merged = (i_rdata & ~w_mask) | (w_shl & w_mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store initiator driving a word-indexed synchronous data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);
  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = r_state == ST_IDLE;
  assign w_err = misaligned(req_size, req_addr[1:0]) || (req_addr[31:2] >= 30'(DEPTH));

  lsu_lane_align u_align (
    .i_size     (r_size),
    .i_signed   (r_signed),
    .i_off      (r_off),
    .i_rdata    (mem_rdata),
    .i_wdata    (r_wdata),
    .o_load_data(w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_size <= '0;
      r_signed <= 1'b0;
      r_off <= '0;
      r_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_size <= req_size;
          r_signed <= req_signed;
          r_off <= req_addr[1:0];
          r_wdata <= req_wdata;
          rsp_rdata <= '0;
          if (w_err) r_state <= ST_ERR;
          else begin
            mem_addr <= {2'b00, req_addr[31:2]};
            if (req_write && req_size == SZ_WORD) begin
              mem_we <= 1'b1;
              mem_wdata <= req_wdata;
              r_state <= ST_WR;
            end else begin
              mem_re <= 1'b1;
              r_state <= req_write ? ST_RMW_WAIT : ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          mem_re <= 1'b0;
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          rsp_rdata <= w_load;
          rsp_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_RMW_WAIT: begin
          mem_re <= 1'b0;
          r_state <= ST_RMW_CAP;
        end
        ST_RMW_CAP: begin
          mem_we <= 1'b1;
          mem_wdata <= w_merged;
          r_state <= ST_WR;
        end
        ST_WR: begin
          mem_we <= 1'b0;
          rsp_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          rsp_valid <= 1'b1;
          rsp_error <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
